// File: rtl/wb_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_bus_arbiter_if
// One Wishbone master-side port: request signals flow from the master to the
// slave, and response signals flow back.
//   addr  [31:0]  cycle address
//   cyc           cycle request / bus ownership
//   stb   [3:0]   byte strobes
//   we            write enable
//   wdat  [31:0]  write data
//   rdat  [31:0]  read data (slave -> master)
//   ack           acknowledge (slave -> master)
//   err           error (slave -> master)
// modport master: the side that issues cycles.
// modport slave : the side that answers them.
// ---------------------------------------------------------------------------
interface wb_bus_arbiter_if;
    logic [31:0] addr;
    logic        cyc;
    logic [3:0]  stb;
    logic        we;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;
    logic        err;

    modport master (
        output addr, cyc, stb, we, wdat,
        input  rdat, ack, err
    );

    modport slave (
        input  addr, cyc, stb, we, wdat,
        output rdat, ack, err
    );
endinterface

// File: rtl/wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// wb_bus_arbiter
// Shares the CPU Wishbone port between the instruction fetcher (F) and the
// load/store unit (D). One master owns the bus for its whole cycle; ties are
// broken round-robin, and a watchdog aborts cycles that never get ack/err.
// Ports:
//   i_clk      clock, rising edge
//   i_reset    synchronous active-high reset
//   f_bus      fetcher port (arbiter is the slave side)
//   d_bus      load/store port (arbiter is the slave side)
//   wb_bus     shared bus towards the interconnect (arbiter is the master)
//   o_grant    current owner: 00 none, 01 F, 10 D
//   o_timeout  one-cycle pulse, the cycle after a watchdog abort
// Parameters:
//   TIMEOUT    cycles a granted cycle may wait before abort (0 = disabled)
//   CNT_W      watchdog counter width; TIMEOUT must be < 2**CNT_W
// ---------------------------------------------------------------------------
module wb_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    wb_bus_arbiter_if.slave        f_bus,
    wb_bus_arbiter_if.slave        d_bus,
    wb_bus_arbiter_if.master       wb_bus,
    output logic [1:0]             o_grant,
    output logic                   o_timeout
);

    // State encoding doubles as the o_grant code.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT_F = 2'b01,
        ST_GRANT_D = 2'b10
    } state_t;

    localparam bit               WD_EN     = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic             last_r;       // 0: F served last, 1: D served last
    logic             last_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             timeout_r;

    logic             gnt_f_s;
    logic             gnt_d_s;
    logic             abort_f_s;
    logic             abort_d_s;
    logic             waiting_s;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
    function automatic state_t arb(input logic f, input logic d, input logic last);
        state_t res;
        if (f && d) begin
            res = last ? ST_GRANT_F : ST_GRANT_D;
        end else if (f) begin
            res = ST_GRANT_F;
        end else if (d) begin
            res = ST_GRANT_D;
        end else begin
            res = ST_IDLE;
        end
        return res;
    endfunction

    // Grant decode and watchdog abort detection.
    always_comb begin
        gnt_f_s   = (state_r == ST_GRANT_F);
        gnt_d_s   = (state_r == ST_GRANT_D);
        abort_f_s = 1'b0;
        abort_d_s = 1'b0;
        if (WD_EN && (cnt_r == TIMEOUT_C)) begin
            abort_f_s = gnt_f_s & f_bus.cyc;
            abort_d_s = gnt_d_s & d_bus.cyc;
        end else begin
            abort_f_s = 1'b0;
            abort_d_s = 1'b0;
        end
    end

    // Next-state, round-robin memory and watchdog counter.
    always_comb begin
        state_nxt_s = state_r;
        last_nxt_s  = last_r;
        cnt_nxt_s   = CNT_ZERO;

        case (state_r)
            ST_IDLE: begin
                state_nxt_s = arb(f_bus.cyc, d_bus.cyc, last_r);
            end
            ST_GRANT_F: begin
                // Handover goes straight to D when it is waiting, no idle cycle.
                if (!f_bus.cyc || abort_f_s) begin
                    state_nxt_s = arb(1'b0, d_bus.cyc, last_r);
                    last_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_GRANT_F;
                end
            end
            ST_GRANT_D: begin
                if (!d_bus.cyc || abort_d_s) begin
                    state_nxt_s = arb(f_bus.cyc, 1'b0, last_r);
                    last_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_GRANT_D;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Count only while the owner is still waiting for a response.
        waiting_s = ((gnt_f_s & f_bus.cyc) | (gnt_d_s & d_bus.cyc))
                    & ~wb_bus.ack & ~wb_bus.err & ~abort_f_s & ~abort_d_s;
        if (WD_EN && waiting_s) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nxt_s = CNT_ZERO;
        end
    end

    // State, round-robin bit, watchdog counter and timeout pulse registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r   <= ST_IDLE;
            last_r    <= 1'b1;
            cnt_r     <= CNT_ZERO;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            last_r    <= last_nxt_s;
            cnt_r     <= cnt_nxt_s;
            timeout_r <= abort_f_s | abort_d_s;
        end
    end

    // Bus request mux; everything is held inactive while reset is asserted.
    always_comb begin
        wb_bus.addr = 32'h0000_0000;
        wb_bus.cyc  = 1'b0;
        wb_bus.stb  = 4'b0000;
        wb_bus.we   = 1'b0;
        wb_bus.wdat = 32'h0000_0000;
        o_grant     = 2'b00;
        if (i_reset) begin
            o_grant = 2'b00;
        end else begin
            o_grant = state_r;
            case (state_r)
                ST_GRANT_F: begin
                    wb_bus.addr = f_bus.addr;
                    wb_bus.cyc  = f_bus.cyc & ~abort_f_s;
                    wb_bus.stb  = f_bus.stb;
                    wb_bus.we   = f_bus.we;
                    wb_bus.wdat = f_bus.wdat;
                end
                ST_GRANT_D: begin
                    wb_bus.addr = d_bus.addr;
                    wb_bus.cyc  = d_bus.cyc & ~abort_d_s;
                    wb_bus.stb  = d_bus.stb;
                    wb_bus.we   = d_bus.we;
                    wb_bus.wdat = d_bus.wdat;
                end
                default: begin
                    wb_bus.cyc  = 1'b0;
                end
            endcase
        end
    end

    // Response routing: only the current owner sees ack/err; an abort turns any ack into err.
    always_comb begin
        f_bus.rdat = wb_bus.rdat;
        d_bus.rdat = wb_bus.rdat;
        f_bus.ack  = 1'b0;
        f_bus.err  = 1'b0;
        d_bus.ack  = 1'b0;
        d_bus.err  = 1'b0;
        if (i_reset) begin
            f_bus.ack = 1'b0;
        end else begin
            f_bus.ack = wb_bus.ack & gnt_f_s & f_bus.cyc & ~abort_f_s;
            f_bus.err = (wb_bus.err & gnt_f_s & f_bus.cyc) | abort_f_s;
            d_bus.ack = wb_bus.ack & gnt_d_s & d_bus.cyc & ~abort_d_s;
            d_bus.err = (wb_bus.err & gnt_d_s & d_bus.cyc) | abort_d_s;
        end
    end

    assign o_timeout = timeout_r;

endmodule
